apple2_paddle_timers: RTL and testbench

Parametrised multi-channel game-port paddle timer: a digital replacement for the Apple II 558 quad timer that drives the paddle input bits of GAMEPORT. Each channel converts a signed 8-bit analog joystick value into a one-shot pulse, counted in CPU-rate ticks and triggered by the paddle strobe (C07x read). Successor to the fixed two-axis paddle logic in the top level. It adds:
- N channels
- per-channel enable with "unplugged" behaviour
- a digital (deadband) mode
- a strobe that is held until the next tick, so a short strobe pulse is not lost

---
 rtl/apple2_paddle_timers.sv | 143 ++++++++++++++
 tb/tb_apple2_paddle_timers.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple2_paddle_timers.sv
`default_nettype none
// ============================================================================
//  Module   : apple2_paddle_timers
//  Purpose  : Multi-channel game-port paddle timer (558 quad-timer
//             replacement). Each channel turns a signed 8-bit joystick value
//             into a one-shot pulse measured in CPU-rate ticks, triggered by
//             the paddle strobe. Supports per-channel enable ("unplugged"),
//             a digital deadband mode and a strobe held until the next tick.
//  Revision : 1.0 - initial release
// ============================================================================
module apple2_paddle_timers #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 13,
  parameter int CENTER     = 2800,
  parameter int SCALE      = 22,
  parameter int SAT_THRESH = 5590,
  parameter int MAX_COUNT  = 5650,
  parameter int DEADBAND   = 32
) (
  input  logic                    CLK_14M,
  input  logic                    RESET_N,
  input  logic                    CLK_2M,
  input  logic                    PDL_STROBE,
  input  logic [8*CHANNELS-1:0]   JOY_AN,
  input  logic [CHANNELS-1:0]     CHAN_EN,
  input  logic                    DIGITAL,
  output logic [CHANNELS-1:0]     PDL,
  output logic                    BUSY
);

  localparam logic [CNT_W-1:0] c_max_count = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] c_center    = CNT_W'(CENTER);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  // Load value for one channel. Analog mode scales around CENTER and clamps
  // to [0, MAX_COUNT]; digital mode snaps to one of three positions; an
  // unplugged channel always reads full scale.
  function automatic logic [CNT_W-1:0] f_load(
    input logic [7:0] a,
    input logic       en,
    input logic       dig
  );
    logic signed [31:0] a_ext;
    logic signed [31:0] v;
    logic [CNT_W-1:0]   r;
    a_ext = {{24{a[7]}}, a};
    v     = CENTER + SCALE * a_ext;
    if (!en) begin
      r = c_max_count;
    end else if (dig) begin
      if (a_ext <= -DEADBAND) begin
        r = '0;
      end else if (a_ext >= DEADBAND) begin
        r = c_max_count;
      end else begin
        r = c_center;
      end
    end else if (v < 0) begin
      r = '0;
    end else if (v >= SAT_THRESH) begin
      r = c_max_count;
    end else begin
      r = v[CNT_W-1:0];
    end
    return r;
  endfunction

  logic clk2m_cur_q;
  logic clk2m_cur_d;
  logic clk2m_prev_q;
  logic clk2m_prev_d;
  logic pend_q;
  logic pend_d;
  logic w_tick;
  logic w_load_due;

  // Tick detection and strobe latch: a strobe seen on any cycle is held
  // until the next tick, which consumes it (including a strobe on that tick).
  always_comb begin
    clk2m_cur_d  = CLK_2M;
    clk2m_prev_d = clk2m_cur_q;
    w_tick       = clk2m_cur_q & ~clk2m_prev_q;
    w_load_due   = w_tick & (pend_q | PDL_STROBE);
    pend_d       = w_tick ? 1'b0 : (pend_q | PDL_STROBE);
  end

  // Shared state: CLK_2M sample history and pending-strobe flag.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      clk2m_cur_q  <= 1'b0;
      clk2m_prev_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      clk2m_cur_q  <= clk2m_cur_d;
      clk2m_prev_q <= clk2m_prev_d;
      pend_q       <= pend_d;
    end
  end

  logic [CHANNELS-1:0] w_cnt_nz;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] w_load;
    logic             pdl_q;
    logic             pdl_d;

    // Per-tick update: output reflects the pre-tick count, then the counter
    // either reloads (retrigger wins) or decrements toward zero.
    always_comb begin
      w_load = f_load(JOY_AN[8*gi +: 8], CHAN_EN[gi], DIGITAL);
      cnt_d  = cnt_q;
      pdl_d  = pdl_q;
      if (w_tick) begin
        pdl_d = |cnt_q;
        if (w_load_due) begin
          cnt_d = w_load;
        end else if (|cnt_q) begin
          cnt_d = cnt_q - c_one;
        end
      end
    end

    // Channel counter and registered paddle output.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt_q <= '0;
        pdl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        pdl_q <= pdl_d;
      end
    end

    assign w_cnt_nz[gi] = |cnt_q;
    assign PDL[gi]      = pdl_q;
  end

  assign BUSY = |w_cnt_nz;

endmodule
`default_nettype wire

// File: tb/tb_apple2_paddle_timers.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apple2_paddle_timers
//  Purpose  : Self-checking bench for apple2_paddle_timers with a behavioural
//             tick-level model and randomized stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apple2_paddle_timers;

  localparam int CH     = 4;
  localparam int CENTER = 2800;
  localparam int SCALE  = 22;
  localparam int SAT    = 5590;
  localparam int MAXC   = 5650;
  localparam int DB     = 32;

  logic          CLK_14M    = 1'b0;
  logic          RESET_N    = 1'b1;
  logic          CLK_2M     = 1'b0;
  logic          PDL_STROBE = 1'b0;
  logic [8*CH-1:0] JOY_AN   = '0;
  logic [CH-1:0] CHAN_EN    = '1;
  logic          DIGITAL    = 1'b0;
  logic [CH-1:0] PDL;
  logic          BUSY;

  int n_checks = 0;
  int n_pass   = 0;
  bit slow_2m  = 1'b0;

  apple2_paddle_timers dut (
    .CLK_14M    (CLK_14M),
    .RESET_N    (RESET_N),
    .CLK_2M     (CLK_2M),
    .PDL_STROBE (PDL_STROBE),
    .JOY_AN     (JOY_AN),
    .CHAN_EN    (CHAN_EN),
    .DIGITAL    (DIGITAL),
    .PDL        (PDL),
    .BUSY       (BUSY)
  );

  always #5 CLK_14M = ~CLK_14M;

  // CPU-rate clock: one high cycle, then a short random or a long fixed low phase.
  initial begin
    forever begin
      @(negedge CLK_14M); CLK_2M = 1'b1;
      @(negedge CLK_14M); CLK_2M = 1'b0;
      if (slow_2m) repeat (5) @(negedge CLK_14M);
      else repeat ($urandom_range(0, 1)) @(negedge CLK_14M);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int load_of(input logic [7:0] a, input bit en, input bit dig);
    int s;
    int v;
    s = $signed(a);
    if (!en) return MAXC;
    if (dig) begin
      if (s <= -DB) return 0;
      if (s >= DB) return MAXC;
      return CENTER;
    end
    v = CENTER + SCALE * s;
    if (v < 0) return 0;
    if (v >= SAT) return MAXC;
    return v % 8192;
  endfunction

  logic [1:0]    m_hist   = 2'b00;   // bit0 = latest CLK_2M sample, bit1 = previous
  bit            m_pend   = 1'b0;
  bit            m_ticked = 1'b0;
  bit            m_due;
  int            m_rem [CH];
  logic [CH-1:0] m_pdl    = '0;
  int            m_tickno = 0;
  int            m_loads  = 0;
  int            m_load_tick = 0;

  function automatic bit m_busy();
    for (int i = 0; i < CH; i++) if (m_rem[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      m_hist   = 2'b00;
      m_pend   = 1'b0;
      m_ticked = 1'b0;
      m_pdl    = '0;
      for (int i = 0; i < CH; i++) m_rem[i] = 0;
    end else begin
      m_ticked = (m_hist == 2'b01);
      if (m_ticked) begin
        m_tickno++;
        m_due = m_pend || PDL_STROBE;
        for (int i = 0; i < CH; i++) begin
          m_pdl[i] = (m_rem[i] != 0);
          if (m_due) m_rem[i] = load_of(JOY_AN[8*i +: 8], CHAN_EN[i], DIGITAL);
          else if (m_rem[i] > 0) m_rem[i]--;
        end
        if (m_due) begin
          m_loads++;
          m_load_tick = m_tickno;
        end
        m_pend = 1'b0;
      end else if (PDL_STROBE) begin
        m_pend = 1'b1;
      end
      m_hist = {m_hist[0], CLK_2M};
    end
  end

  // ---------------- compare process and pulse measurement ----------------
  int            hi_ticks [CH];
  int            rises    [CH];
  logic [CH-1:0] prev_pdl = '0;

  always @(negedge CLK_14M) begin
    chk("pdl", PDL, m_pdl);
    chk("busy", BUSY, m_busy());
    for (int j = 0; j < CH; j++) begin
      if (m_ticked && PDL[j]) hi_ticks[j]++;
      if (PDL[j] && !prev_pdl[j]) rises[j]++;
    end
    prev_pdl = PDL;
  end

  task automatic clear_meas();
    for (int i = 0; i < CH; i++) begin
      hi_ticks[i] = 0;
      rises[i]    = 0;
    end
  endtask

  // Assumes the caller is sitting at a falling clock edge.
  task automatic pulse_strobe();
    PDL_STROBE = 1'b1;
    @(negedge CLK_14M);
    PDL_STROBE = 1'b0;
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge CLK_14M);
      k++;
    end while (!m_ticked && k < 100);
    if (k >= 100) chk("tick_timeout", k, 0);
  endtask

  task automatic wait_tickno(input int target);
    int k = 0;
    while (m_tickno < target && k < 40000) begin
      @(negedge CLK_14M);
      k++;
    end
    if (k >= 40000) chk("tickno_timeout", k, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_pend || m_busy() || m_pdl != 0) && k < 40000) begin
      @(negedge CLK_14M);
      k++;
    end
    if (k >= 40000) chk("idle_timeout", k, 0);
    repeat (4) @(negedge CLK_14M);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int t0;
    int l2;
    for (int i = 0; i < CH; i++) m_rem[i] = 0;
    clear_meas();

    // Pin the model's load rule with hand-computed values.
    chk("model_centre", load_of(8'h00, 1'b1, 1'b0), 2800);
    chk("model_sat_hi", load_of(8'h7F, 1'b1, 1'b0), 5650);
    chk("model_sat_lo", load_of(8'h80, 1'b1, 1'b0), 0);
    chk("model_dig_mid", load_of(8'h10, 1'b1, 1'b1), 2800);
    chk("model_dig_neg", load_of(8'hE0, 1'b1, 1'b1), 0);
    chk("model_dig_pos", load_of(8'h20, 1'b1, 1'b1), 5650);
    chk("model_unplug", load_of(8'h80, 1'b0, 1'b0), 5650);

    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK_14M);
    chk("reset_pdl", PDL, 0);
    chk("reset_busy", BUSY, 0);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK_14M);

    // Centre value, single strobe a few cycles after a tick.
    slow_2m = 1'b1;
    wait_tick(); wait_tick();
    clear_meas();
    repeat (2) @(negedge CLK_14M);
    pulse_strobe();
    slow_2m = 1'b0;
    wait_idle();
    chk("centre_hi", hi_ticks[0], 2800);
    chk("centre_rises", rises[0], 1);

    // Saturation plus two strobes inside one tick period.
    JOY_AN  = {8'($urandom), 8'($urandom), 8'h80, 8'h7F};
    l2      = load_of(JOY_AN[23:16], 1'b1, 1'b0);
    slow_2m = 1'b1;
    wait_tick(); wait_tick();
    clear_meas();
    t0 = m_loads;
    pulse_strobe();
    @(negedge CLK_14M);
    pulse_strobe();
    slow_2m = 1'b0;
    wait_idle();
    chk("double_strobe_loads", m_loads - t0, 1);
    chk("sat_hi_ch0", hi_ticks[0], 5650);
    chk("sat_rises_ch0", rises[0], 1);
    chk("sat_lo_ch1", hi_ticks[1], 0);
    chk("rand_ch2", hi_ticks[2], l2);

    // Retrigger 1000 ticks into a centre pulse.
    JOY_AN = '0;
    clear_meas();
    t0 = m_loads;
    @(negedge CLK_14M);
    pulse_strobe();
    while (m_loads == t0) @(negedge CLK_14M);
    wait_tickno(m_load_tick + 999);
    pulse_strobe();
    wait_idle();
    chk("retrig_hi", hi_ticks[0], 3800);
    chk("retrig_rises", rises[0], 1);

    // Digital mode with channel 3 unplugged.
    DIGITAL = 1'b1;
    CHAN_EN = 4'b0111;
    JOY_AN  = {8'h80, 8'h20, 8'hE0, 8'h10};
    clear_meas();
    @(negedge CLK_14M);
    pulse_strobe();
    wait_idle();
    chk("dig_ch0", hi_ticks[0], 2800);
    chk("dig_ch1", hi_ticks[1], 0);
    chk("dig_ch2", hi_ticks[2], 5650);
    chk("unplug_ch3", hi_ticks[3], 5650);

    // Reset in the middle of a pulse, with a strobe pending.
    DIGITAL = 1'b0;
    CHAN_EN = '1;
    JOY_AN  = '0;
    t0 = m_loads;
    @(negedge CLK_14M);
    pulse_strobe();
    while (m_loads == t0) @(negedge CLK_14M);
    wait_tickno(m_load_tick + 500);
    pulse_strobe();
    #2 RESET_N = 1'b0;
    #1;
    chk("midreset_pdl", PDL, 0);
    chk("midreset_busy", BUSY, 0);
    repeat (3) @(negedge CLK_14M);
    RESET_N = 1'b1;
    clear_meas();
    wait_tickno(m_tickno + 200);
    chk("post_reset_rises", rises[0] + rises[1] + rises[2] + rises[3], 0);
    chk("post_reset_busy", BUSY, 0);

    // Randomized phase: random values, modes, enables and strobes.
    for (int n = 0; n < 25; n++) begin
      @(negedge CLK_14M);
      JOY_AN     = 32'($urandom);
      CHAN_EN    = 4'($urandom);
      DIGITAL    = 1'($urandom);
      PDL_STROBE = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 120)) begin
        @(negedge CLK_14M);
        PDL_STROBE = ($urandom_range(0, 15) == 0);
      end
    end
    PDL_STROBE = 1'b0;
    @(negedge CLK_14M);
    #2 RESET_N = 1'b0;
    #1;
    chk("final_reset_pdl", PDL, 0);
    repeat (2) @(negedge CLK_14M);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
